// File: rtl/ep_issue_stage_pkg.sv
// Shared types for the even-pipe issue stage: opcodes, forwarding packet layout,
// pending/issued instruction records and the operand-use decoder.
package ep_issue_stage_pkg;

    localparam int unsigned EP_PKT_W = 143;

    typedef enum logic [6:0] {
        OpNop         = 7'd0,
        OpAddWord     = 7'd1,
        OpAnd         = 7'd2,
        OpMultiply    = 7'd3,
        OpImmLoadWord = 7'd4,
        OpSelectBits  = 7'd5,
        OpAddWordImm  = 7'd6,
        OpMultiplyAdd = 7'd7
    } opcode_t;

    localparam opcode_t EP_NOP = OpNop;

    // Big-endian layout: value occupies bits [0:127], i.e. the most significant end.
    typedef struct packed {
        logic [0:127] value;
        logic [0:6]   rt_addr;
        logic         we;
        logic [0:3]   lat;
        logic [0:2]   unit_id;
    } ep_pkt_t;

    typedef struct packed {
        opcode_t      op;
        logic [6:0]   ra_addr;
        logic [6:0]   rb_addr;
        logic [6:0]   rc_addr;
        logic [6:0]   rt_addr;
        logic [6:0]   i7;
        logic [9:0]   i10;
        logic [15:0]  i16;
        logic [17:0]  i18;
    } ep_instr_t;

    typedef struct packed {
        opcode_t      op;
        logic [127:0] ra;
        logic [127:0] rb;
        logic [127:0] rc;
        logic [6:0]   rt;
        logic [6:0]   i7;
        logic [9:0]   i10;
        logic [15:0]  i16;
        logic [17:0]  i18;
    } ep_issue_t;

    localparam ep_issue_t ISSUE_NONE = '{
        op: EP_NOP, ra: '0, rb: '0, rc: '0, rt: '0, i7: '0, i10: '0, i16: '0, i18: '0
    };

    // Returns {ra, rb, rc} operand-use mask.
    function automatic logic [2:0] uses_ops(opcode_t op);
        unique case (op)
            OpAddWord, OpAnd, OpMultiply:  uses_ops = 3'b110;
            OpSelectBits, OpMultiplyAdd:   uses_ops = 3'b111;
            OpAddWordImm:                  uses_ops = 3'b100;
            default:                       uses_ops = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/ep_issue_stage_operand_forward.sv
// Resolves one source operand against the forwarding packets and the write-back packet,
// returning the forwarded or register-file value, or a hazard if the youngest match is not ready.
module ep_operand_forward
    import ep_issue_stage_pkg::*;
#(
    parameter int unsigned NUM_FW_STAGES = 7
) (
    input  logic [6:0]   addr_i,
    input  logic [127:0] rf_data_i,
    input  ep_pkt_t      fw_pkts_i [NUM_FW_STAGES],
    input  ep_pkt_t      wb_pkt_i,
    output logic [127:0] value_o,
    output logic         hazard_o
);

    logic unused_fields;

    always_comb begin
        value_o  = rf_data_i;
        hazard_o = 1'b0;
        if (wb_pkt_i.we && (wb_pkt_i.rt_addr == addr_i)) begin
            value_o = wb_pkt_i.value;
        end
        // Walk oldest to youngest so the youngest match has the final word.
        for (int k = NUM_FW_STAGES; k >= 1; k--) begin
            if (fw_pkts_i[k-1].we && (fw_pkts_i[k-1].rt_addr == addr_i)) begin
                hazard_o = int'(fw_pkts_i[k-1].lat) > k;
                value_o  = hazard_o ? '0 : fw_pkts_i[k-1].value;
            end
        end
    end

    always_comb begin
        unused_fields = ^{wb_pkt_i.lat, wb_pkt_i.unit_id};
        for (int k = 0; k < NUM_FW_STAGES; k++) begin
            unused_fields = unused_fields ^ (^fw_pkts_i[k].unit_id);
        end
    end

endmodule

// File: rtl/ep_issue_stage.sv
// Even-pipe operand fetch and issue: holds one pending instruction, resolves its operands
// through forwarding, and issues it or stalls decode while a producer is still in flight.
module ep_issue_stage
    import ep_issue_stage_pkg::*;
#(
    parameter int unsigned NUM_FW_STAGES = 7,
    parameter int unsigned STALL_CNT_W   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  opcode_t                in_op_code,
    input  logic [6:0]             in_ra_addr,
    input  logic [6:0]             in_rb_addr,
    input  logic [6:0]             in_rc_addr,
    input  logic [6:0]             in_rt_addr,
    input  logic [6:0]             in_I7,
    input  logic [9:0]             in_I10,
    input  logic [15:0]            in_I16,
    input  logic [17:0]            in_I18,
    output logic [6:0]             rf_ra_addr,
    output logic [6:0]             rf_rb_addr,
    output logic [6:0]             rf_rc_addr,
    input  logic [127:0]           rf_ra_data,
    input  logic [127:0]           rf_rb_data,
    input  logic [127:0]           rf_rc_data,
    input  ep_pkt_t                fw_ep_st_1,
    input  ep_pkt_t                fw_ep_st_2,
    input  ep_pkt_t                fw_ep_st_3,
    input  ep_pkt_t                fw_ep_st_4,
    input  ep_pkt_t                fw_ep_st_5,
    input  ep_pkt_t                fw_ep_st_6,
    input  ep_pkt_t                fw_ep_st_7,
    input  ep_pkt_t                wb_ep,
    output opcode_t                ep_op_code,
    output logic [127:0]           ra_out,
    output logic [127:0]           rb_out,
    output logic [127:0]           rc_out,
    output logic [6:0]             rt_address_out,
    output logic [6:0]             I7_out,
    output logic [9:0]             I10_out,
    output logic [15:0]            I16_out,
    output logic [17:0]            I18_out,
    output logic                   issue_valid,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [0:0] {StEmpty, StHold} pend_state_e;

    pend_state_e            state_q, state_d;
    ep_instr_t              pend_q, pend_d;
    ep_issue_t              out_q, out_d;
    logic                   valid_q, valid_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    ep_pkt_t      fw_pkts [NUM_FW_STAGES];
    logic [6:0]   opnd_addr [3];
    logic [127:0] opnd_rf [3];
    logic [127:0] opnd_val [3];
    logic [2:0]   opnd_haz;
    logic [2:0]   use_mask;
    logic         hazard;
    logic         issue;

    assign fw_pkts[0] = fw_ep_st_1;
    assign fw_pkts[1] = fw_ep_st_2;
    assign fw_pkts[2] = fw_ep_st_3;
    assign fw_pkts[3] = fw_ep_st_4;
    assign fw_pkts[4] = fw_ep_st_5;
    assign fw_pkts[5] = fw_ep_st_6;
    assign fw_pkts[6] = fw_ep_st_7;

    // Operand index 2/1/0 = ra/rb/rc, lining up with the uses_ops mask bits.
    assign opnd_addr[2] = pend_q.ra_addr;
    assign opnd_addr[1] = pend_q.rb_addr;
    assign opnd_addr[0] = pend_q.rc_addr;
    assign opnd_rf[2]   = rf_ra_data;
    assign opnd_rf[1]   = rf_rb_data;
    assign opnd_rf[0]   = rf_rc_data;

    for (genvar g = 0; g < 3; g++) begin : g_opnd
        ep_operand_forward #(
            .NUM_FW_STAGES(NUM_FW_STAGES)
        ) u_fwd (
            .addr_i   (opnd_addr[g]),
            .rf_data_i(opnd_rf[g]),
            .fw_pkts_i(fw_pkts),
            .wb_pkt_i (wb_ep),
            .value_o  (opnd_val[g]),
            .hazard_o (opnd_haz[g])
        );
    end

    assign use_mask = uses_ops(pend_q.op);
    assign hazard   = (state_q == StHold) && |(use_mask & opnd_haz);
    assign issue    = (state_q == StHold) && !hazard;
    assign in_ready = (state_q == StEmpty) || !hazard;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        out_d       = ISSUE_NONE;
        valid_d     = 1'b0;
        stall_cnt_d = stall_cnt_q;

        if (issue) begin
            out_d.op  = pend_q.op;
            out_d.ra  = use_mask[2] ? opnd_val[2] : '0;
            out_d.rb  = use_mask[1] ? opnd_val[1] : '0;
            out_d.rc  = use_mask[0] ? opnd_val[0] : '0;
            out_d.rt  = pend_q.rt_addr;
            out_d.i7  = pend_q.i7;
            out_d.i10 = pend_q.i10;
            out_d.i16 = pend_q.i16;
            out_d.i18 = pend_q.i18;
            valid_d   = 1'b1;
        end

        if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end

        if (in_valid && in_ready) begin
            state_d        = StHold;
            pend_d.op      = in_op_code;
            pend_d.ra_addr = in_ra_addr;
            pend_d.rb_addr = in_rb_addr;
            pend_d.rc_addr = in_rc_addr;
            pend_d.rt_addr = in_rt_addr;
            pend_d.i7      = in_I7;
            pend_d.i10     = in_I10;
            pend_d.i16     = in_I16;
            pend_d.i18     = in_I18;
        end else if (issue) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StEmpty;
            pend_q      <= '0;
            out_q       <= ISSUE_NONE;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rf_ra_addr     = pend_q.ra_addr;
    assign rf_rb_addr     = pend_q.rb_addr;
    assign rf_rc_addr     = pend_q.rc_addr;
    assign ep_op_code     = out_q.op;
    assign ra_out         = out_q.ra;
    assign rb_out         = out_q.rb;
    assign rc_out         = out_q.rc;
    assign rt_address_out = out_q.rt;
    assign I7_out         = out_q.i7;
    assign I10_out        = out_q.i10;
    assign I16_out        = out_q.i16;
    assign I18_out        = out_q.i18;
    assign issue_valid    = valid_q;
    assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_ep_issue_stage.sv
// Bench for ep_issue_stage: directed scenarios with literal expectations, then randomized
// instructions and forwarding traffic compared every cycle against a behavioural model.
module tb_ep_issue_stage;
    import ep_issue_stage_pkg::*;

    logic clock, reset;
    logic in_valid, in_ready;
    opcode_t in_op_code, ep_op_code;
    logic [6:0] in_ra_addr, in_rb_addr, in_rc_addr, in_rt_addr, in_I7;
    logic [9:0] in_I10;
    logic [15:0] in_I16;
    logic [17:0] in_I18;
    logic [6:0] rf_ra_addr, rf_rb_addr, rf_rc_addr;
    logic [127:0] rf_ra_data, rf_rb_data, rf_rc_data;
    logic [127:0] ra_out, rb_out, rc_out;
    logic [6:0] rt_address_out, I7_out;
    logic [9:0] I10_out;
    logic [15:0] I16_out;
    logic [17:0] I18_out;
    logic issue_valid;
    logic [15:0] stall_count;

    // Packet slots 1..7 are the forwarding stages, slot 8 is write-back.
    logic [127:0] pv [1:8];
    logic [6:0]   pa [1:8];
    logic         pw [1:8];
    logic [3:0]   pl [1:8];
    logic [2:0]   pu [1:8];
    logic [142:0] pk [1:8];
    logic [127:0] rf [128];

    always_comb for (int s = 1; s <= 8; s++) pk[s] = {pv[s], pa[s], pw[s], pl[s], pu[s]};
    assign rf_ra_data = rf[rf_ra_addr];
    assign rf_rb_data = rf[rf_rb_addr];
    assign rf_rc_data = rf[rf_rc_addr];

    ep_issue_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op_code(in_op_code), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
        .in_rc_addr(in_rc_addr), .in_rt_addr(in_rt_addr), .in_I7(in_I7), .in_I10(in_I10),
        .in_I16(in_I16), .in_I18(in_I18), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_rc_addr(rf_rc_addr), .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
        .rf_rc_data(rf_rc_data), .fw_ep_st_1(pk[1]), .fw_ep_st_2(pk[2]), .fw_ep_st_3(pk[3]),
        .fw_ep_st_4(pk[4]), .fw_ep_st_5(pk[5]), .fw_ep_st_6(pk[6]), .fw_ep_st_7(pk[7]),
        .wb_ep(pk[8]), .ep_op_code(ep_op_code), .ra_out(ra_out), .rb_out(rb_out),
        .rc_out(rc_out), .rt_address_out(rt_address_out), .I7_out(I7_out), .I10_out(I10_out),
        .I16_out(I16_out), .I18_out(I18_out), .issue_valid(issue_valid),
        .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Which sources each op reads: bit 0 = ra, bit 1 = rb, bit 2 = rc.
    function automatic logic [2:0] need(opcode_t op);
        case (op)
            OpAddWord, OpAnd, OpMultiply: return 3'b011;
            OpSelectBits, OpMultiplyAdd:  return 3'b111;
            OpAddWordImm:                 return 3'b001;
            default:                      return 3'b000;
        endcase
    endfunction

    // First matching writer in stage order 1..7 then write-back decides the operand.
    task automatic resolve(input logic [6:0] a, output logic [127:0] v, output logic h);
        bit found;
        found = 0;
        v = rf[a];
        h = 0;
        for (int s = 1; s <= 8; s++) begin
            if (!found && pw[s] && pa[s] == a) begin
                found = 1;
                if (s == 8 || s >= int'(pl[s])) v = pv[s];
                else begin
                    v = '0;
                    h = 1;
                end
            end
        end
    endtask

    // Model state: pending instruction and the outputs expected after the next edge.
    bit m_pv, m_acc, chk_en;
    opcode_t m_op, e_op;
    logic [6:0] m_a [3];
    logic [6:0] m_rt, m_i7, e_rt, e_i7;
    logic [9:0] m_i10, e_i10;
    logic [15:0] m_i16, e_i16;
    logic [17:0] m_i18, e_i18;
    logic [127:0] e_opnd [3];
    bit e_valid;
    int m_cnt, e_cnt;

    initial begin
        m_pv = 0; m_acc = 0; chk_en = 0; m_cnt = 0;
    end

    always @(negedge clock) begin
        logic [127:0] v [3];
        logic h [3];
        logic [2:0] nd;
        bit hz, rdy, iss;
        nd = need(m_op);
        hz = 0;
        for (int j = 0; j < 3; j++) begin
            resolve(m_a[j], v[j], h[j]);
            if (m_pv && nd[j] && h[j]) hz = 1;
        end
        rdy = !m_pv || !hz;
        if (chk_en) begin
            chk("issue_valid", 128'(issue_valid), 128'(e_valid));
            chk("op_code", 128'(ep_op_code), 128'(e_op));
            chk("ra_out", ra_out, e_opnd[0]);
            chk("rb_out", rb_out, e_opnd[1]);
            chk("rc_out", rc_out, e_opnd[2]);
            chk("rt_out", 128'(rt_address_out), 128'(e_rt));
            chk("I7_out", 128'(I7_out), 128'(e_i7));
            chk("I10_out", 128'(I10_out), 128'(e_i10));
            chk("I16_out", 128'(I16_out), 128'(e_i16));
            chk("I18_out", 128'(I18_out), 128'(e_i18));
            chk("stall_count", 128'(stall_count), 128'(e_cnt));
            chk("in_ready", 128'(in_ready), 128'(rdy));
        end
        iss = m_pv && !hz;
        m_acc = reset && in_valid && rdy;
        e_valid = reset && iss;
        e_op = e_valid ? m_op : OpNop;
        for (int j = 0; j < 3; j++) e_opnd[j] = (e_valid && nd[j]) ? v[j] : '0;
        e_rt = e_valid ? m_rt : '0;
        e_i7 = e_valid ? m_i7 : '0;
        e_i10 = e_valid ? m_i10 : '0;
        e_i16 = e_valid ? m_i16 : '0;
        e_i18 = e_valid ? m_i18 : '0;
        if (!reset) begin
            m_pv = 0;
            m_cnt = 0;
        end else begin
            if (m_pv && hz && m_cnt < 65535) m_cnt++;
            if (m_acc) begin
                m_pv = 1; m_op = in_op_code; m_rt = in_rt_addr;
                m_a[0] = in_ra_addr; m_a[1] = in_rb_addr; m_a[2] = in_rc_addr;
                m_i7 = in_I7; m_i10 = in_I10; m_i16 = in_I16; m_i18 = in_I18;
            end else if (iss) m_pv = 0;
        end
        e_cnt = m_cnt;
        if (!reset) chk_en = 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_pkts();
        for (int s = 1; s <= 8; s++) begin
            pv[s] = '0; pa[s] = '0; pw[s] = 0; pl[s] = '0; pu[s] = '0;
        end
    endtask

    task automatic set_pkt(input int s, input logic [127:0] v, input logic [6:0] a,
                           input logic [3:0] l);
        pv[s] = v; pa[s] = a; pw[s] = 1; pl[s] = l; pu[s] = 3'd1;
    endtask

    // Advance every packet one stage; optionally inject a random new one at stage 1.
    task automatic shift_pkts(input bit gen);
        for (int s = 8; s >= 2; s--) begin
            pv[s] = pv[s-1]; pa[s] = pa[s-1]; pw[s] = pw[s-1]; pl[s] = pl[s-1]; pu[s] = pu[s-1];
        end
        pv[1] = {$urandom, $urandom, $urandom, $urandom};
        pa[1] = 7'($urandom_range(0, 7));
        pw[1] = gen && ($urandom_range(0, 1) == 1);
        pl[1] = 4'($urandom_range(1, 7));
        pu[1] = 3'($urandom);
    endtask

    task automatic present(input opcode_t op, input logic [6:0] ra, input logic [6:0] rb,
                           input logic [6:0] rc, input logic [15:0] i16);
        in_valid = 1; in_op_code = op; in_ra_addr = ra; in_rb_addr = rb; in_rc_addr = rc;
        in_rt_addr = 7'd9; in_I7 = '0; in_I10 = '0; in_I16 = i16; in_I18 = '0;
    endtask

    initial begin
        reset = 0;
        in_valid = 0;
        present(OpNop, 0, 0, 0, 0);
        in_valid = 0;
        clr_pkts();
        for (int i = 0; i < 128; i++) rf[i] = {$urandom, $urandom, $urandom, $urandom};
        rf[3] = 128'd20;
        rf[4] = 128'd10;
        tick();
        tick();
        reset = 1;
        tick();
        chk("rst_issue_valid", 128'(issue_valid), 128'd0);
        chk("rst_stall_count", 128'(stall_count), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);

        // Plain add from the register file.
        present(OpAddWord, 3, 4, 0, 0);
        tick();
        in_valid = 0;
        chk("add_accept_ready", 128'(in_ready), 128'd1);
        tick();
        chk("add_valid", 128'(issue_valid), 128'd1);
        chk("add_ra", ra_out, 128'd20);
        chk("add_rb", rb_out, 128'd10);

        // Ready forward from stage 2 overrides the RF.
        set_pkt(2, 128'd99, 3, 4'd2);
        present(OpAddWord, 3, 4, 0, 0);
        tick();
        in_valid = 0;
        tick();
        chk("fwd_st2_ra", ra_out, 128'd99);
        chk("fwd_st2_stall", 128'(stall_count), 128'd0);
        clr_pkts();

        // Latency-7 producer walks stage 1..7 while its consumer waits.
        present(OpAnd, 5, 4, 0, 0);
        tick();
        in_valid = 0;
        set_pkt(1, 128'd777, 5, 4'd7);
        #1;
        chk("lat7_ready_low", 128'(in_ready), 128'd0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("lat7_nop", 128'(issue_valid), 128'd0);
            shift_pkts(0);
            #1;
            if (i < 6) chk("lat7_hold_ready", 128'(in_ready), 128'd0);
        end
        tick();
        chk("lat7_issue", 128'(issue_valid), 128'd1);
        chk("lat7_ra", ra_out, 128'd777);
        chk("lat7_stalls", 128'(stall_count), 128'd6);
        clr_pkts();

        // Youngest match wins, whether or not an older one is ready.
        set_pkt(3, 128'd7, 5, 4'd2);
        set_pkt(6, 128'd9, 5, 4'd1);
        present(OpAnd, 5, 4, 0, 0);
        tick();
        in_valid = 0;
        tick();
        chk("young_ra", ra_out, 128'd7);
        chk("young_rb", rb_out, 128'd10);
        set_pkt(3, 128'd7, 5, 4'd5);
        present(OpAnd, 5, 4, 0, 0);
        tick();
        in_valid = 0;
        #1;
        chk("young_nr_ready", 128'(in_ready), 128'd0);
        tick();
        chk("young_nr_nop", 128'(issue_valid), 128'd0);
        pw[3] = 0;
        tick();
        chk("young_nr_ra", ra_out, 128'd9);
        chk("young_nr_stalls", 128'(stall_count), 128'd7);
        clr_pkts();

        // Hazard on an operand the op never reads.
        set_pkt(1, 128'd1, 5, 4'd7);
        present(OpImmLoadWord, 5, 0, 0, 16'd374);
        tick();
        in_valid = 0;
        tick();
        chk("ilw_valid", 128'(issue_valid), 128'd1);
        chk("ilw_i16", 128'(I16_out), 128'd374);
        chk("ilw_ra", ra_out, 128'd0);
        chk("ilw_stalls", 128'(stall_count), 128'd7);

        // Reset in the middle of a stall drops the held instruction.
        present(OpAnd, 5, 4, 0, 0);
        tick();
        in_valid = 0;
        tick();
        reset = 0;
        tick();
        reset = 1;
        clr_pkts();
        #1;
        chk("rst_stall_valid", 128'(issue_valid), 128'd0);
        chk("rst_stall_cnt", 128'(stall_count), 128'd0);
        chk("rst_stall_ready", 128'(in_ready), 128'd1);
        tick();
        chk("rst_dropped", 128'(issue_valid), 128'd0);

        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!in_valid || m_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op_code = opcode_t'($urandom_range(1, 7));
                in_ra_addr = 7'($urandom_range(0, 7));
                in_rb_addr = 7'($urandom_range(0, 7));
                in_rc_addr = 7'($urandom_range(0, 7));
                in_rt_addr = 7'($urandom_range(0, 7));
                in_I7 = 7'($urandom);
                in_I10 = 10'($urandom);
                in_I16 = 16'($urandom);
                in_I18 = 18'($urandom);
            end
            shift_pkts(1);
            reset = ($urandom_range(0, 199) != 0);
        end
        reset = 1;
        in_valid = 0;
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
